// File: rtl/memory_bi_param.sv
// Single-port register memory on a bidirectional data bus.
// The array is swept to zero after reset and on a clr request; busy marks the sweep.
module memory_bi_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rw,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  rvalid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // Bus protocol: the master owns data whenever rw=1; the block drives it only
    // while rvalid=1, i.e. in the cycle after an accepted read while en=1 and rw=0.
    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_drive;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic                    w_rd_accept;
    logic                    w_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_drive <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_drive <= w_rd_accept;
            if (w_rd_accept) begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = addr;
        w_mem_wdata  = data;
        w_rd_accept  = 1'b0;
        case (r_state)
            S_CLEAR: begin
                // clr and accesses are ignored; the counter wraps to 0 on the last word
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cnt;
                w_mem_wdata = '0;
                w_cnt_next  = r_cnt + CNT_ONE;
                if (r_cnt == '1) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = '0;
                end else if (en && rw) begin
                    w_mem_we = 1'b1;
                end else if (en) begin
                    w_rd_accept = 1'b1;
                end
            end
            default: begin
                w_state_next = S_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // en and rw gate the driver combinationally so the bus is released the moment rw rises.
    assign w_oe   = r_drive & en & ~rw;
    assign rvalid = w_oe;
    assign busy   = (r_state == S_CLEAR);
    assign data   = w_oe ? r_rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_memory_bi_param.sv
// Directed bench for memory_bi_param: default 8x32 instance plus a 16x8 instance.
module tb_memory_bi_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst_a = 1'b1, en_a = 1'b0, rw_a = 1'b0, clr_a = 1'b0;
    logic [4:0] addr_a = '0;
    logic       busy_a, rvalid_a;
    wire  [7:0] data_a;
    logic       drv_a = 1'b0;
    logic [7:0] dat_a = '0;
    assign data_a = drv_a ? dat_a : 8'hzz;

    // 16-bit, 8-word instance
    logic        rst_b = 1'b1, en_b = 1'b0, rw_b = 1'b0, clr_b = 1'b0;
    logic [2:0]  addr_b = '0;
    logic        busy_b, rvalid_b;
    wire  [15:0] data_b;
    logic        drv_b = 1'b0;
    logic [15:0] dat_b = '0;
    assign data_b = drv_b ? dat_b : 16'hzzzz;

    int n_checks = 0;
    int n_pass   = 0;

    memory_bi_param dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .rw(rw_a), .clr(clr_a),
        .addr(addr_a), .data(data_a), .busy(busy_a), .rvalid(rvalid_a)
    );

    memory_bi_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .rw(rw_b), .clr(clr_b),
        .addr(addr_b), .data(data_b), .busy(busy_b), .rvalid(rvalid_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // drivers: called at a falling edge, return at a falling edge with the bus idle
    task automatic wr_a(input logic [4:0] a, input logic [7:0] d);
        en_a = 1'b1; rw_a = 1'b1; addr_a = a; drv_a = 1'b1; dat_a = d;
        @(negedge clk);
        en_a = 1'b0; drv_a = 1'b0;
    endtask

    task automatic rd_a(input logic [4:0] a, output logic [7:0] d, output logic v);
        en_a = 1'b1; rw_a = 1'b0; addr_a = a;
        @(posedge clk); #1;
        d = data_a; v = rvalid_a;
        @(negedge clk);
        en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [15:0] d);
        en_b = 1'b1; rw_b = 1'b1; addr_b = a; drv_b = 1'b1; dat_b = d;
        @(negedge clk);
        en_b = 1'b0; drv_b = 1'b0;
    endtask

    task automatic rd_b(input logic [2:0] a, output logic [15:0] d, output logic v);
        en_b = 1'b1; rw_b = 1'b0; addr_b = a;
        @(posedge clk); #1;
        d = data_b; v = rvalid_b;
        @(negedge clk);
        en_b = 1'b0;
    endtask

    // counts rising edges until busy is seen low; 200 means it never fell
    task automatic count_busy_a(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!busy_a) break;
        end
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!busy_b) break;
        end
    endtask

    task automatic test_reset;
        int n;
        logic [7:0] d;
        logic v;
        logic [4:0] addrs [3];
        addrs = '{5'd0, 5'd17, 5'd31};
        #1;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy_a); else n_pass++;
        n_checks++;
        if (rvalid_a !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid_a); else n_pass++;
        @(negedge clk);
        rst_a = 1'b0;
        count_busy_a(n);
        n_checks++;
        if (n !== 32) $display("FAIL reset_sweep_len: got %0d edges want 32", n); else n_pass++;
        @(negedge clk);
        foreach (addrs[i]) begin
            rd_a(addrs[i], d, v);
            n_checks++;
            if (d !== 8'h00 || v !== 1'b1)
                $display("FAIL reset_read_zero[%0d]: got data %h rvalid %b want 00 1", addrs[i], d, v);
            else n_pass++;
        end
    endtask

    task automatic test_write_read;
        logic [7:0] d;
        logic v;
        wr_a(5'd1, 8'h02);
        rd_a(5'd1, d, v);
        n_checks++;
        if (d !== 8'h02 || v !== 1'b1) $display("FAIL wr_rd_addr1: got %h/%b want 02/1", d, v); else n_pass++;
        rd_a(5'd2, d, v);
        n_checks++;
        if (d !== 8'h00 || v !== 1'b1) $display("FAIL rd_addr2: got %h/%b want 00/1", d, v); else n_pass++;
        wr_a(5'd4, 8'h11);
        wr_a(5'd5, 8'h22);
        rd_a(5'd4, d, v);
        n_checks++;
        if (d !== 8'h11) $display("FAIL rd_addr4: got %h want 11", d); else n_pass++;
        rd_a(5'd5, d, v);
        n_checks++;
        if (d !== 8'h22) $display("FAIL rd_addr5: got %h want 22", d); else n_pass++;
    endtask

    task automatic test_release;
        logic [7:0] d;
        logic v;
        en_a = 1'b1; rw_a = 1'b0; addr_a = 5'd1;
        @(posedge clk); #1;
        n_checks++;
        if (data_a !== 8'h02 || rvalid_a !== 1'b1)
            $display("FAIL release_read: got %h/%b want 02/1", data_a, rvalid_a);
        else n_pass++;
        @(negedge clk);
        rw_a = 1'b1; drv_a = 1'b1; dat_a = 8'h3C;
        #1;
        n_checks++;
        if (rvalid_a !== 1'b0) $display("FAIL release_rvalid: got %b want 0", rvalid_a); else n_pass++;
        n_checks++;
        if (data_a !== 8'h3C) $display("FAIL release_bus: got %h want 3c", data_a); else n_pass++;
        @(negedge clk);
        en_a = 1'b0; drv_a = 1'b0;
        rd_a(5'd1, d, v);
        n_checks++;
        if (d !== 8'h3C) $display("FAIL release_write_taken: got %h want 3c", d); else n_pass++;
        en_a = 1'b1; rw_a = 1'b0; addr_a = 5'd1;
        @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        #1;
        n_checks++;
        if (rvalid_a !== 1'b0) $display("FAIL en_drop_rvalid: got %b want 0", rvalid_a); else n_pass++;
    endtask

    task automatic test_clear;
        int n;
        int bad_rv;
        logic [7:0] d;
        logic v;
        wr_a(5'd31, 8'hA5);
        rd_a(5'd31, d, v);
        n_checks++;
        if (d !== 8'hA5) $display("FAIL clr_pre_read: got %h want a5", d); else n_pass++;
        clr_a = 1'b1; en_a = 1'b1; rw_a = 1'b1; addr_a = 5'd3; drv_a = 1'b1; dat_a = 8'h77;
        @(posedge clk); #1;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL clr_busy_rise: got %b want 1", busy_a); else n_pass++;
        n = 0;
        bad_rv = 0;
        while (n < 200) begin
            @(negedge clk);
            clr_a = (n == 4);
            en_a = 1'b1;
            if (n % 4 == 3) begin
                rw_a = 1'b0; drv_a = 1'b0;
            end else begin
                rw_a = 1'b1; drv_a = 1'b1;
                addr_a = (n % 2 == 0) ? 5'd3 : 5'd31;
                dat_a = (n % 2 == 0) ? 8'h77 : 8'hFF;
            end
            @(posedge clk); #1;
            n++;
            if (rvalid_a !== 1'b0) bad_rv++;
            if (!busy_a) break;
        end
        n_checks++;
        if (n !== 32) $display("FAIL clr_sweep_len: got %0d edges want 32", n); else n_pass++;
        n_checks++;
        if (bad_rv !== 0) $display("FAIL clr_rvalid_during_busy: got %0d cycles high want 0", bad_rv); else n_pass++;
        @(negedge clk);
        en_a = 1'b0; clr_a = 1'b0; drv_a = 1'b0;
        rd_a(5'd31, d, v);
        n_checks++;
        if (d !== 8'h00) $display("FAIL clr_addr31: got %h want 00", d); else n_pass++;
        rd_a(5'd3, d, v);
        n_checks++;
        if (d !== 8'h00) $display("FAIL clr_addr3: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_reset_midsweep;
        int n;
        logic [7:0] d;
        logic v;
        wr_a(5'd9, 8'hC3);
        en_a = 1'b1; rw_a = 1'b0; addr_a = 5'd9;
        @(posedge clk); #1;
        n_checks++;
        if (data_a !== 8'hC3 || rvalid_a !== 1'b1)
            $display("FAIL midread_data: got %h/%b want c3/1", data_a, rvalid_a);
        else n_pass++;
        #2 rst_a = 1'b1;
        #1;
        n_checks++;
        if (rvalid_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL midread_rst_async: got rvalid %b busy %b want 0 1", rvalid_a, busy_a);
        else n_pass++;
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b0;
        count_busy_a(n);
        n_checks++;
        if (n !== 32) $display("FAIL midread_sweep_len: got %0d edges want 32", n); else n_pass++;
        @(negedge clk);
        rd_a(5'd9, d, v);
        n_checks++;
        if (d !== 8'h00) $display("FAIL midread_addr9: got %h want 00", d); else n_pass++;
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL midsweep_busy: got %b want 1", busy_a); else n_pass++;
        #2 rst_a = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL midsweep_rst_busy: got %b want 1", busy_a); else n_pass++;
        @(negedge clk);
        rst_a = 1'b0;
        count_busy_a(n);
        n_checks++;
        if (n !== 32) $display("FAIL midsweep_restart_len: got %0d edges want 32", n); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_param;
        int n;
        logic [15:0] d;
        logic v;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy_b !== 1'b1) $display("FAIL p16_reset_busy: got %b want 1", busy_b); else n_pass++;
        @(negedge clk);
        rst_b = 1'b0;
        count_busy_b(n);
        n_checks++;
        if (n !== 8) $display("FAIL p16_sweep_len: got %0d edges want 8", n); else n_pass++;
        @(negedge clk);
        wr_b(3'd7, 16'hBEEF);
        rd_b(3'd7, d, v);
        n_checks++;
        if (d !== 16'hBEEF || v !== 1'b1) $display("FAIL p16_addr7: got %h/%b want beef/1", d, v); else n_pass++;
        rd_b(3'd0, d, v);
        n_checks++;
        if (d !== 16'h0000) $display("FAIL p16_addr0: got %h want 0000", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_release();
        test_clear();
        test_reset_midsweep();
        test_param();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_bi_param.md
MEMORY_BI_PARAM -- requirements
Module: memory_bi_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one memory word and of the data bus.
REQ-002 Parameter ADDR_WIDTH, default 5: address width; DEPTH = 2**ADDR_WIDTH words (default 32).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  access enable; no access when low.
REQ-006 rw  input  1  1 = write (master drives data), 0 = read (block drives data).
REQ-007 clr  input  1  request to zero the whole array, sampled on the rising edge.
REQ-008 addr  input  ADDR_WIDTH  word address.
REQ-009 data  inout  DATA_WIDTH  bidirectional data bus.
REQ-010 busy  output  1  high while a clear sweep is in progress; accesses are ignored.
REQ-011 rvalid  output  1  high while the block is driving valid read data on data.

Function
REQ-012 Storage SHALL be DEPTH x DATA_WIDTH registers with a single port: one access per cycle.
REQ-013 State machine SHALL have two states: CLEAR and IDLE.
REQ-014 CLEAR SHALL write 0 to mem[cnt] on each rising edge, then increment cnt (ADDR_WIDTH bits).
REQ-015 When cnt = DEPTH-1 in CLEAR, that word SHALL be zeroed, the FSM SHALL go to IDLE, and cnt SHALL wrap to 0.
REQ-016 A full sweep SHALL take exactly DEPTH cycles.
REQ-017 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-018 In IDLE, clr=1 at a rising edge SHALL move the FSM to CLEAR with cnt=0; clr has priority over an access on the same edge, which is dropped.
REQ-019 clr in CLEAR SHALL have no effect and SHALL NOT restart the sweep.
REQ-020 Write: in IDLE with en=1, rw=1, clr=0 at a rising edge, data SHALL be stored in mem[addr].
REQ-021 Read: in IDLE with en=1, rw=0, clr=0 at a rising edge, mem[addr] SHALL be captured into rdata_q and drive_q SHALL be set to 1.
REQ-022 On any rising edge without an accepted read, drive_q SHALL be cleared to 0.
REQ-023 Read latency SHALL be one cycle: captured data is visible on data after the accepting edge and remains until the next edge.
REQ-024 Output enable SHALL be drive_q AND en AND NOT rw, combinational.
  - data = rdata_q when enabled, otherwise high-Z.
  - rvalid = the output enable.
  - The block SHALL release the bus in the same cycle rw rises, so there is no contention with the master.
REQ-025 A read on the edge after a write to the same address SHALL return the newly written value.
REQ-026 Accesses during CLEAR SHALL have no effect on memory, rdata_q or drive_q; drive_q is 0.
REQ-027 Addresses SHALL use the full ADDR_WIDTH range; there is no out-of-range case.

Reset
REQ-028 Asserting rst SHALL immediately, without a clock, force:
  - FSM = CLEAR, cnt = 0
  - drive_q = 0, rdata_q = 0
  - busy = 1, rvalid = 0, data = high-Z
REQ-029 After rst deasserts, the block SHALL run a full sweep, so every word reads 0 after busy falls.
REQ-030 rst asserted mid-sweep or mid-read SHALL abort the operation and restart from REQ-028.

Verification
REQ-031 Reset, then count cycles -> busy=1 for exactly 32 rising edges, then 0; read of any address returns 8'h00.
REQ-032 IDLE; write addr=1 data=8'h02; next edge read addr=1 -> after that edge data=8'h02 and rvalid=1; addr=2 read -> 8'h00.
REQ-033 Read of addr=1 accepted, then rw=1 in the following cycle -> block drives high-Z and rvalid=0 in that same cycle; no X on data.
REQ-034 Write 8'hA5 to addr=31, pulse clr -> busy=1 for 32 cycles; writes issued during busy are ignored; then addr=31 reads 8'h00.
REQ-035 rst pulsed at sweep cycle 10 -> busy stays 1, sweep restarts at cnt=0, takes 32 more cycles.
REQ-036 Instance with DATA_WIDTH=16, ADDR_WIDTH=3 -> sweep takes 8 cycles; write 16'hBEEF to addr=7 reads back 16'hBEEF one cycle after the read edge.
